// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-Lite response codes and the master controller state encoding.
package axi_lite_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_RD_REQ,
    ST_WR_RESP,
    ST_RD_DATA,
    ST_RSP
  } state_e;
endpackage

// File: rtl/axi_lite_master_ctrl.sv
// axi_lite_master_ctrl: single-outstanding AXI4-Lite initiator turning one command into one
// write (AW+W+B) or read (AR+R) transaction and returning data, status and latency.
module axi_lite_master_ctrl
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT_W  = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic [LAT_W-1:0]    rsp_latency,
  output logic [ADDR_W-1:0]   axi_awaddr,
  output logic                axi_awvalid,
  input  logic                axi_awready,
  output logic [DATA_W-1:0]   axi_wdata,
  output logic [DATA_W/8-1:0] axi_wstrb,
  output logic                axi_wvalid,
  input  logic                axi_wready,
  input  logic [1:0]          axi_bresp,
  input  logic                axi_bvalid,
  output logic                axi_bready,
  output logic [ADDR_W-1:0]   axi_araddr,
  output logic                axi_arvalid,
  input  logic                axi_arready,
  input  logic [DATA_W-1:0]   axi_rdata,
  input  logic [1:0]          axi_rresp,
  input  logic                axi_rvalid,
  output logic                axi_rready
);
  state_e                state_q;
  logic                  cmd_ready_q, rsp_valid_q, write_q;
  logic                  awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q, rdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic [1:0]            resp_q;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  aw_done, w_done;
  always_comb begin
    lat_d   = &lat_q ? lat_q : lat_q + LAT_W'(1);
    aw_done = !awvalid_q || axi_awready;
    w_done  = !wvalid_q || axi_wready;
  end
  // A channel's own valid doubles as its "still pending" flag, so AW and W retire independently.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      write_q     <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
      lat_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= !(cmd_valid && cmd_ready_q);
          if (cmd_valid && cmd_ready_q) begin
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            write_q   <= cmd_write;
            lat_q     <= '0;
            awvalid_q <= cmd_write;
            wvalid_q  <= cmd_write;
            arvalid_q <= !cmd_write;
            state_q   <= cmd_write ? ST_WR_REQ : ST_RD_REQ;
          end
        end
        ST_WR_REQ: begin
          lat_q <= lat_d;
          if (axi_awready) awvalid_q <= 1'b0;
          if (axi_wready) wvalid_q <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end
        ST_RD_REQ: begin
          lat_q <= lat_d;
          if (axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_DATA;
          end
        end
        ST_WR_RESP: begin
          lat_q <= lat_d;
          if (axi_bvalid) begin
            resp_q      <= axi_bresp;
            rdata_q     <= '0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end
        ST_RD_DATA: begin
          lat_q <= lat_d;
          if (axi_rvalid) begin
            resp_q      <= axi_rresp;
            rdata_q     <= axi_rdata;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = write_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_latency = lat_q;
  assign axi_awaddr  = addr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;
  assign axi_araddr  = addr_q;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;
endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// tb_axi_lite_master_ctrl: directed and random checks of the AXI4-Lite master against a
// configurable-delay slave model and a reference memory.
module tb_axi_lite_master_ctrl;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  rsp_latency;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic [3:0]  axi_wstrb;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [1:0]  axi_bresp, axi_rresp;
  int tests = 0, fails = 0;
  always #5 aclk = ~aclk;
  axi_lite_master_ctrl #(.ADDR_W(32), .DATA_W(32), .LAT_W(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_latency(rsp_latency),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Slave model: each ready rises after its configured number of waiting cycles.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] smem [0:255];
  logic [31:0] ref_mem [0:255];
  logic aw_have, w_have, ar_have;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0] s_wstrb;
  assign axi_awready = axi_awvalid && !aw_have && aw_cnt == aw_dly;
  assign axi_wready  = axi_wvalid && !w_have && w_cnt == w_dly;
  assign axi_arready = axi_arvalid && !ar_have && ar_cnt == ar_dly;
  always @(posedge aclk) begin
    if (!aresetn) begin
      aw_have <= 0; w_have <= 0; ar_have <= 0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      axi_bvalid <= 0; axi_rvalid <= 0; axi_bresp <= 0; axi_rresp <= 0; axi_rdata <= 0;
    end else begin
      if (axi_awvalid && axi_awready) begin aw_have <= 1; s_awaddr <= axi_awaddr; aw_cnt <= 0; end
      else if (axi_awvalid && !aw_have) aw_cnt <= aw_cnt + 1;
      if (axi_wvalid && axi_wready) begin w_have <= 1; s_wdata <= axi_wdata; s_wstrb <= axi_wstrb; w_cnt <= 0; end
      else if (axi_wvalid && !w_have) w_cnt <= w_cnt + 1;
      if (axi_arvalid && axi_arready) begin ar_have <= 1; s_araddr <= axi_araddr; ar_cnt <= 0; end
      else if (axi_arvalid && !ar_have) ar_cnt <= ar_cnt + 1;
      if (aw_have && w_have && !axi_bvalid) begin
        if (b_cnt == b_dly) begin
          axi_bvalid <= 1;
          axi_bresp <= b_resp_cfg;
          for (int i = 0; i < 4; i++)
            if (s_wstrb[i]) smem[s_awaddr[9:2]][8*i+:8] <= s_wdata[8*i+:8];
        end else b_cnt <= b_cnt + 1;
      end
      if (axi_bvalid && axi_bready) begin axi_bvalid <= 0; aw_have <= 0; w_have <= 0; b_cnt <= 0; end
      if (ar_have && !axi_rvalid) begin
        if (r_cnt == r_dly) begin
          axi_rvalid <= 1;
          axi_rdata <= smem[s_araddr[9:2]];
          axi_rresp <= r_resp_cfg;
        end else r_cnt <= r_cnt + 1;
      end
      if (axi_rvalid && axi_rready) begin axi_rvalid <= 0; ar_have <= 0; r_cnt <= 0; end
    end
  end
  // Protocol monitor: a valid without handshake must stay up with stable payload.
  logic p_aw = 0, p_w = 0, p_ar = 0;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0] p_wstrb;
  int aw_hs = 0, w_hs = 0, b_hs = 0, split_aw = 0, split_w = 0;
  always @(negedge aclk) begin
    if (!aresetn) begin
      p_aw <= 0; p_w <= 0; p_ar <= 0;
    end else begin
      if (p_aw) chk("aw_hold", {axi_awvalid, axi_awaddr}, {1'b1, p_awaddr});
      if (p_w) chk("w_hold", {axi_wvalid, axi_wstrb, axi_wdata}, {1'b1, p_wstrb, p_wdata});
      if (p_ar) chk("ar_hold", {axi_arvalid, axi_araddr}, {1'b1, p_araddr});
      p_aw <= axi_awvalid && !axi_awready; p_awaddr <= axi_awaddr;
      p_w <= axi_wvalid && !axi_wready; p_wdata <= axi_wdata; p_wstrb <= axi_wstrb;
      p_ar <= axi_arvalid && !axi_arready; p_araddr <= axi_araddr;
      aw_hs <= aw_hs + int'(axi_awvalid && axi_awready);
      w_hs <= w_hs + int'(axi_wvalid && axi_wready);
      b_hs <= b_hs + int'(axi_bvalid && axi_bready);
      split_aw <= split_aw + int'(axi_awvalid && !axi_wvalid);
      split_w <= split_w + int'(axi_wvalid && !axi_awvalid);
    end
  end
  // Issue one command from a negedge; checks the response, its stability while stalled, and the return to idle.
  task automatic do_cmd(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int hold, input logic [31:0] exp_d,
                        input logic [1:0] exp_r, input logic [3:0] exp_l, output int cyc);
    int n = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
    chk({tag, "_accept"}, cmd_ready, 1);
    @(posedge aclk);
    @(negedge aclk);
    cmd_valid = 0;
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge aclk); n++; end
    cyc = n;
    if (wr)
      for (int i = 0; i < 4; i++) if (s[i]) ref_mem[a[9:2]][8*i+:8] = d[8*i+:8];
    chk(tag, {rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_latency}, {1'b1, wr, exp_d, exp_r, exp_l});
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      chk({tag, "_stall"}, {rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_latency}, {1'b1, wr, exp_d, exp_r, exp_l});
    end
    rsp_ready = 1;
    @(negedge aclk);
    rsp_ready = 0;
    chk({tag, "_done"}, {rsp_valid, cmd_ready}, 2'b01);
  endtask
  initial begin
    int cyc, b0, aw0, sp0;
    logic wr;
    logic [31:0] a, d, ed;
    logic [3:0] s, el;
    int mx;
    for (int i = 0; i < 256; i++) begin smem[i] = '0; ref_mem[i] = '0; end
    repeat (3) @(negedge aclk);
    chk("reset_outs", {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready, cmd_ready,
                       rsp_valid, rsp_latency, rsp_rdata, rsp_resp, axi_awaddr}, '0);
    aresetn = 1;
    @(negedge aclk);
    chk("post_reset_ready", cmd_ready, 1);
    b0 = b_hs; aw0 = aw_hs;
    do_cmd("wr_full", 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 4'd3, cyc);
    chk("wr_full_cycles", cyc, 3);
    chk("wr_full_hs", {aw_hs - aw0, b_hs - b0}, {32'd1, 32'd1});
    do_cmd("rd_full", 0, 32'h100, 0, 0, 0, 32'hDEADBEEF, 2'b00, 4'd3, cyc);
    chk("rd_full_cycles", cyc, 3);
    do_cmd("wr_half", 1, 32'h100, 32'h0000CAFE, 4'b0011, 0, 0, 2'b00, 4'd3, cyc);
    do_cmd("rd_half", 0, 32'h100, 0, 0, 0, 32'hDEADCAFE, 2'b00, 4'd3, cyc);
    aw_dly = 3; b0 = b_hs; sp0 = split_aw;
    do_cmd("wr_aw_late", 1, 32'h104, 32'h11223344, 4'hF, 0, 0, 2'b00, 4'd6, cyc);
    chk("wr_aw_late_b", b_hs - b0, 1);
    chk("wr_aw_late_split", split_aw > sp0, 1);
    aw_dly = 0; w_dly = 3; b0 = b_hs; sp0 = split_w;
    do_cmd("wr_w_late", 1, 32'h108, 32'h55667788, 4'hF, 0, 0, 2'b00, 4'd6, cyc);
    chk("wr_w_late_b", b_hs - b0, 1);
    chk("wr_w_late_split", split_w > sp0, 1);
    w_dly = 0;
    do_cmd("rd_104", 0, 32'h104, 0, 0, 0, 32'h11223344, 2'b00, 4'd3, cyc);
    r_dly = 5; r_resp_cfg = 2'b10;
    do_cmd("rd_slverr", 0, 32'h100, 0, 0, 4, 32'hDEADCAFE, 2'b10, 4'd8, cyc);
    r_dly = 0; r_resp_cfg = 2'b00;
    b_dly = 2; b_resp_cfg = 2'b11;
    do_cmd("wr_decerr", 1, 32'h10C, 32'h0BADF00D, 4'hF, 1, 0, 2'b11, 4'd5, cyc);
    b_dly = 0; b_resp_cfg = 2'b00;
    r_dly = 20;
    do_cmd("rd_lat_sat", 0, 32'h108, 0, 0, 0, 32'h55667788, 2'b00, 4'd15, cyc);
    r_dly = 0;
    aw_dly = 10;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h200; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
    @(posedge aclk);
    @(negedge aclk);
    cmd_valid = 0;
    chk("mid_valids", {axi_awvalid, axi_wvalid}, 2'b11);
    @(posedge aclk);
    #2 aresetn = 0;
    #1 chk("mid_reset_drop", {axi_awvalid, axi_wvalid, axi_arvalid, cmd_ready}, 4'b0000);
    repeat (2) @(negedge aclk);
    aresetn = 1; aw_dly = 0;
    @(negedge aclk);
    chk("mid_reset_after", {cmd_ready, rsp_valid, axi_awvalid}, 3'b100);
    do_cmd("wr_after_rst", 1, 32'h200, 32'hA5A5A5A5, 4'hF, 0, 0, 2'b00, 4'd3, cyc);
    do_cmd("rd_after_rst", 0, 32'h200, 0, 0, 0, 32'hA5A5A5A5, 2'b00, 4'd3, cyc);
    for (int k = 0; k < 100; k++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      wr = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 255)) << 2;
      d = $urandom;
      s = 4'($urandom);
      mx = aw_dly > w_dly ? aw_dly : w_dly;
      el = wr ? 4'(3 + mx + b_dly) : 4'(3 + ar_dly + r_dly);
      ed = wr ? 32'h0 : ref_mem[a[9:2]];
      do_cmd(wr ? "rand_wr" : "rand_rd", wr, a, d, s, $urandom_range(0, 2), ed, 2'b00, el, cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
